control_unit: RTL
=================

# control_unit

Fetch/decode/execute sequencer for the SimpleComputer datapath. Generates the per-cycle control strobes for the instruction register, program counter, accumulator/ALU and memory bus. Sequencing is driven by the 8-bit opcode the instruction register presents and by a memory-ready handshake. Sits beside the instruction register and owns every load and enable line of the datapath.

## Interface
- No parameters. Opcode width is 8 and fixed.
- CLK  input  1  system clock; rising-edge.
- AR_N  input  1  asynchronous reset, active-low.
- RUN  input  1  start execution from IDLE.
- IOP  input  8  opcode field from instruction register, `ir[15:8]`.
- Z  input  1  accumulator-zero flag.
- MRDY  input  1  memory ready; read data valid, or write accepted, this cycle.
- IRL  output  1  instruction register load.
- IRA  output  1  instruction register drives operand onto the address bus.
- PCA  output  1  program counter drives the address bus.
- PCI  output  1  program counter increment.
- PCL  output  1  program counter load from the address bus.
- MRD  output  1  memory read request.
- MWR  output  1  memory write request.
- ACL  output  1  accumulator load from ALU.
- ACD  output  1  accumulator drives the data bus.
- ALU_OP  output  2  ALU function: 0 = PASS, 1 = ADD, 2 = SUB.
- HLT  output  1  halted.
- ERR  output  1  halted on an illegal opcode.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT. The state register is cleared asynchronously to IDLE.
- Opcodes: NOP 0x00, LOAD 0x01, STORE 0x02, ADD 0x03, SUB 0x04, JMP 0x05, JZ 0x06, HALT 0xFF. Every other value is illegal.
- IDLE: all outputs 0. Moves to FETCH when RUN = 1.
- FETCH: PCA = 1, MRD = 1, IRL = MRDY. Moves to DECODE on MRDY; holds otherwise.
- DECODE: PCI = 1.
  - Next state is EXEC for LOAD, STORE, ADD, SUB, JMP and JZ.
  - Next state is FETCH for NOP.
  - Next state is HALT for HALT and for illegal opcodes. An illegal opcode sets the ERR flag register.
- EXEC, decoded from the IOP value latched during DECODE:
  - LOAD, ADD, SUB: IRA = 1, MRD = 1, ALU_OP = PASS/ADD/SUB respectively, ACL = MRDY. Leaves on MRDY.
  - STORE: IRA = 1, MWR = 1, ACD = 1. Leaves on MRDY.
  - JMP: IRA = 1, PCL = 1. Lasts one cycle.
  - JZ: IRA = Z, PCL = Z. Lasts one cycle.
  - EXEC always returns to FETCH.
- HALT: HLT = 1; ERR holds its flag value. Only AR_N exits this state; RUN is ignored.
- Gating rules:
  - MRD and MWR are never both 1.
  - PCA and IRA are never both 1.
  - ACL, IRL and PCL are never asserted without their source driving the bus.

## Timing
- Reset: every output is 0 and ALU_OP = 0 while AR_N = 0 and in the first cycle after release.
- Strobes are combinational from state, the latched opcode, and MRDY/Z. No strobe depends on RUN outside IDLE.
- Latency with MRDY tied high:
  - NOP: 2 cycles.
  - LOAD, STORE, ADD, SUB, JMP, JZ: 3 cycles.
  - Each MRDY = 0 cycle in FETCH or a memory EXEC extends the instruction by one cycle. Strobes stay stable throughout.
- IOP is sampled only at the DECODE edge. Changes to IOP in EXEC have no effect.
- AR_N asserted mid-instruction aborts immediately to IDLE and clears ERR.

## Configuration
- `SC_WAIT_STATE_EN` defined: MRDY handshake as above.
- `SC_WAIT_STATE_EN` undefined: MRDY is ignored and treated as 1; every memory state lasts exactly one cycle. The port remains present.

## Structure
- Package `sc_pkg` holds:
  - opcode localparams;
  - the state enum;
  - ALU_OP encodings.
- Sub-module `cu_decode` maps the latched opcode to an instruction class, a legal flag and an ALU_OP. It is purely combinational.

## Test plan
- Reset, then RUN, fetch IOP = 0x01 with MRDY = 1: verify IDLE→FETCH→DECODE→EXEC→FETCH. IRL pulses in FETCH, PCI in DECODE, ACL with ALU_OP = 0 in EXEC.
- STORE (0x02) with MRDY low for 2 EXEC cycles: MWR, ACD and IRA are held for 3 cycles, then the sequencer returns to FETCH.
- JZ (0x06): with Z = 1, PCL = 1 for one cycle; with Z = 0, PCL = 0. Both cases take 3 cycles.
- IOP = 0x7A: HALT state with HLT = 1 and ERR = 1, RUN ignored. AR_N low clears both.
- AR_N low during LOAD EXEC: all outputs go to 0 asynchronously, and the state is IDLE after release.
- Build without `SC_WAIT_STATE_EN` and hold MRDY = 0: ADD still completes in 3 cycles.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the SimpleComputer control unit: opcodes, sequencer
// states, decoded instruction classes and ALU function encodings.
package sc_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_JMP   = 8'h05;
    localparam logic [7:0] OP_JZ    = 8'h06;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // LOAD, ADD and SUB share one class: they differ only in ALU function.
    localparam logic [2:0] CLS_NOP   = 3'd0;
    localparam logic [2:0] CLS_MEMRD = 3'd1;
    localparam logic [2:0] CLS_STORE = 3'd2;
    localparam logic [2:0] CLS_JMP   = 3'd3;
    localparam logic [2:0] CLS_JZ    = 3'd4;
    localparam logic [2:0] CLS_HALT  = 3'd5;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: instruction class, legality and ALU function.
module cu_decode
    import sc_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [2:0] iclass,
    output logic       legal,
    output logic [1:0] alu_op
);

    // Opcode classification; unknown opcodes decode as an illegal halt.
    always_comb begin
        iclass = CLS_HALT;
        legal  = 1'b1;
        alu_op = ALU_PASS;
        case (opcode)
            OP_NOP:   iclass = CLS_NOP;
            OP_LOAD:  iclass = CLS_MEMRD;
            OP_STORE: iclass = CLS_STORE;
            OP_ADD: begin
                iclass = CLS_MEMRD;
                alu_op = ALU_ADD;
            end
            OP_SUB: begin
                iclass = CLS_MEMRD;
                alu_op = ALU_SUB;
            end
            OP_JMP:   iclass = CLS_JMP;
            OP_JZ:    iclass = CLS_JZ;
            OP_HALT:  iclass = CLS_HALT;
            default: begin
                iclass = CLS_HALT;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving every datapath strobe.
// Optional macro SC_WAIT_STATE_EN enables the MRDY wait-state handshake.
module control_unit
    import sc_pkg::*;
(
    input  logic       CLK,
    input  logic       AR_N,
    input  logic       RUN,
    input  logic [7:0] IOP,
    input  logic       Z,
    input  logic       MRDY,
    output logic       IRL,
    output logic       IRA,
    output logic       PCA,
    output logic       PCI,
    output logic       PCL,
    output logic       MRD,
    output logic       MWR,
    output logic       ACL,
    output logic       ACD,
    output logic [1:0] ALU_OP,
    output logic       HLT,
    output logic       ERR
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] op_r;
    logic       err_r;
    logic       mrdy_s;
    logic [7:0] dec_op_s;
    logic [2:0] cls_s;
    logic       legal_s;
    logic [1:0] alu_s;

`ifdef SC_WAIT_STATE_EN
    assign mrdy_s = MRDY;
`else
    logic unused_mrdy_s;
    assign unused_mrdy_s = MRDY;
    assign mrdy_s        = 1'b1;
`endif

    // DECODE classifies the live opcode; EXEC works from the copy latched at that edge.
    assign dec_op_s = (state_r == ST_DECODE) ? IOP : op_r;
    assign ERR      = err_r;

    cu_decode u_decode (
        .opcode (dec_op_s),
        .iclass (cls_s),
        .legal  (legal_s),
        .alu_op (alu_s)
    );

    // State, latched opcode and illegal-opcode flag.
    always_ff @(posedge CLK or negedge AR_N) begin
        if (!AR_N) begin
            state_r <= ST_IDLE;
            op_r    <= 8'h00;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_DECODE) begin
                op_r <= IOP;
                if (!legal_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    // Next-state and strobe generation.
    always_comb begin
        state_nxt_s = state_r;
        IRL    = 1'b0;
        IRA    = 1'b0;
        PCA    = 1'b0;
        PCI    = 1'b0;
        PCL    = 1'b0;
        MRD    = 1'b0;
        MWR    = 1'b0;
        ACL    = 1'b0;
        ACD    = 1'b0;
        ALU_OP = ALU_PASS;
        HLT    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (RUN) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                PCA = 1'b1;
                MRD = 1'b1;
                IRL = mrdy_s;
                if (mrdy_s) begin
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                PCI = 1'b1;
                case (cls_s)
                    CLS_NOP:  state_nxt_s = ST_FETCH;
                    CLS_HALT: state_nxt_s = ST_HALT;
                    default:  state_nxt_s = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                state_nxt_s = ST_FETCH;
                case (cls_s)
                    CLS_MEMRD: begin
                        IRA    = 1'b1;
                        MRD    = 1'b1;
                        ALU_OP = alu_s;
                        ACL    = mrdy_s;
                        if (!mrdy_s) begin
                            state_nxt_s = ST_EXEC;
                        end else begin
                            state_nxt_s = ST_FETCH;
                        end
                    end
                    CLS_STORE: begin
                        IRA = 1'b1;
                        MWR = 1'b1;
                        ACD = 1'b1;
                        if (!mrdy_s) begin
                            state_nxt_s = ST_EXEC;
                        end else begin
                            state_nxt_s = ST_FETCH;
                        end
                    end
                    CLS_JMP: begin
                        IRA = 1'b1;
                        PCL = 1'b1;
                    end
                    CLS_JZ: begin
                        IRA = Z;
                        PCL = Z;
                    end
                    default: state_nxt_s = ST_FETCH;
                endcase
            end
            ST_HALT: begin
                HLT         = 1'b1;
                state_nxt_s = ST_HALT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

endmodule
